// File: rtl/rv64_dmem_responder.sv
// rv64_dmem_responder: dword data RAM, MMIO exit/counter block and backdoor read port.
// Optional macro DMEM_INIT_CLEAR_EN: zero the whole RAM after reset before mem_ready rises.
module rv64_dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [63:0] MMIO_BASE = 64'h0001_0000,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   data_mem_addr,
  input  logic [63:0]   data_mem_wr_data,
  input  logic          data_mem_wr_en,
  output logic [63:0]   data_mem_rd_data,
  output logic          mem_ready,
  output logic          done,
  output logic [62:0]   exit_code,
  output logic [63:0]   cycle_count,
  output logic [31:0]   err_count,
  input  logic [AW-1:0] dbg_addr,
  output logic [63:0]   dbg_rd_data
);

  localparam logic [63:0] RAM_END  = 64'(DEPTH) * 64'd8;
  localparam logic [63:0] MMIO_END = MMIO_BASE + 64'd32;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

`ifdef DMEM_INIT_CLEAR_EN
  localparam state_t S_RST = S_CLEAR;
`else
  localparam state_t S_RST = S_RUN;
`endif

  state_t r_state;
  state_t w_state_nx;

  logic [63:0]   r_ram [DEPTH];
  logic [63:0]   r_dbg;
  logic [63:0]   r_cyc;
  logic [31:0]   r_wr_cnt;
  logic [31:0]   r_err_cnt;
  logic [63:0]   r_tohost;
  logic [62:0]   r_exit;

  logic [AW-1:0] w_idx;
  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [1:0]    w_mmio_off;
  logic          w_aligned;
  logic          w_we;
  logic          w_ram_we;
  logic          w_err_inc;
  logic          w_host_we;
  logic          w_halt;
  logic          w_clr_last;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_idx;
  logic [63:0]   w_mem_wd;
  logic [63:0]   w_rd;

  assign w_idx      = data_mem_addr[3+AW-1:3];
  assign w_ram_hit  = data_mem_addr < RAM_END;
  assign w_mmio_hit = (data_mem_addr >= MMIO_BASE) &&
                      (data_mem_addr < MMIO_END);
  assign w_mmio_off = data_mem_addr[4:3];
  assign w_aligned  = data_mem_addr[2:0] == 3'd0;

  assign w_we      = data_mem_wr_en && (r_state == S_RUN);
  assign w_ram_we  = w_we && w_aligned && w_ram_hit;
  assign w_err_inc = w_we &&
                     (!w_aligned || (!w_ram_hit && !w_mmio_hit));
  assign w_host_we = w_we && w_aligned && w_mmio_hit &&
                     (w_mmio_off == 2'd0);
  assign w_halt    = w_host_we && data_mem_wr_data[0];

`ifdef DMEM_INIT_CLEAR_EN
  logic [AW-1:0] r_clr_idx;

  assign w_clr_last = r_clr_idx == AW'(DEPTH - 1);

  // Sweep index for the post-reset RAM clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_idx <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_idx <= r_clr_idx + AW'(1);
    end
  end
`else
  assign w_clr_last = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state: clear sweep ends into RUN, TOHOST exit freezes in HALT
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_CLEAR: if (w_clr_last) w_state_nx = S_RUN;
      S_RUN:   if (w_halt) w_state_nx = S_HALT;
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_RST;
    endcase
  end

  // Single RAM write port shared by the clear sweep and core stores
  always_comb begin
    w_mem_we  = w_ram_we;
    w_mem_idx = w_idx;
    w_mem_wd  = data_mem_wr_data;
`ifdef DMEM_INIT_CLEAR_EN
    if (r_state == S_CLEAR) begin
      w_mem_we  = 1'b1;
      w_mem_idx = r_clr_idx;
      w_mem_wd  = '0;
    end
`endif
  end

  // RAM array, no reset so contents survive reset when not cleared
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_ram[w_mem_idx] <= w_mem_wd;
    end
  end

  // Backdoor read, sampled before any same-edge write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg <= '0;
    end else begin
      r_dbg <= r_ram[dbg_addr];
    end
  end

  // Run-time cycle counter, wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
    end else if (r_state == S_RUN) begin
      r_cyc <= r_cyc + 64'd1;
    end
  end

  // Saturating accepted-store and rejected-store counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_ram_we && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 32'd1;
      end
    end
  end

  // TOHOST register and exit code capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tohost <= '0;
      r_exit   <= '0;
    end else begin
      if (w_host_we) begin
        r_tohost <= data_mem_wr_data;
      end
      if (w_halt) begin
        r_exit <= data_mem_wr_data[63:1];
      end
    end
  end

  // Combinational load mux over RAM, MMIO and unmapped space
  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_ram_hit: w_rd = r_ram[w_idx];
      w_mmio_hit: begin
        unique case (w_mmio_off)
          2'd0: w_rd = r_tohost;
          2'd1: w_rd = r_cyc;
          2'd2: w_rd = {32'b0, r_wr_cnt};
          2'd3: w_rd = {32'b0, r_err_cnt};
          default: w_rd = '0;
        endcase
      end
      default: w_rd = '0;
    endcase
  end

  assign data_mem_rd_data = w_rd;
  assign mem_ready        = r_state != S_CLEAR;
  assign done             = r_state == S_HALT;
  assign exit_code        = r_exit;
  assign cycle_count      = r_cyc;
  assign err_count        = r_err_cnt;
  assign dbg_rd_data      = r_dbg;

endmodule

// File: doc/rv64_dmem_responder.md
Name: rv64_dmem_responder

Overview:
- Synthesizable responder for the rv64_core data-memory port. It is the memory/peripheral end of the core's data_mem_* initiator interface.
- Provides a dword-organised data RAM with combinational read and registered write.
- Provides a small MMIO block: TOHOST exit register, cycle counter, write counter and error counter.
- Provides a registered backdoor read port for checkers. Lets benches and FPGA top-levels detect program completion without hierarchical peeks.

Parameters:
- DEPTH, 4096: number of 64-bit dwords in the RAM. RAM byte range is 0 to DEPTH*8-1.
- MMIO_BASE, 64'h0001_0000: byte base of the MMIO block. Must be ≥ DEPTH*8 and 32-byte aligned.
- AW, $clog2(DEPTH): dword index width, derived.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- data_mem_addr  in  64  byte address from core
- data_mem_wr_data  in  64  store data
- data_mem_wr_en  in  1  store strobe, sampled at posedge clk
- data_mem_rd_data  out  64  combinational load data
- mem_ready  out  1  RAM usable; bench/top holds core reset until high
- done  out  1  program signalled completion via TOHOST
- exit_code  out  63  TOHOST[63:1] captured at completion
- cycle_count  out  64  cycles spent in RUN
- err_count  out  32  rejected stores
- dbg_addr  in  AW  backdoor dword index
- dbg_rd_data  out  64  backdoor data, 1-cycle latency

Behaviour:
- Reset values: data_mem_rd_data follows its combinational rules. mem_ready=0 if clearing is enabled, else 1. done=0, exit_code=0, cycle_count=0, err_count=0, wr_count=0, dbg_rd_data=0.
- FSM states and transitions:
  - CLEAR to RUN when the clear index reaches DEPTH-1.
  - RUN to HALT on a valid TOHOST write with wr_data[0]=1.
  - HALT is left only by reset.
  - Async reset in any state, including mid-CLEAR, returns to the reset state. A CLEAR sweep restarts at index 0.
- Address decode, using idx = addr[3+AW-1:3]:
  - RAM hit: addr < DEPTH*8.
  - MMIO hit: MMIO_BASE ≤ addr < MMIO_BASE+32.
  - Anything else is unmapped.
- Reads (combinational, every state):
  - RAM hit: ram[idx]. Low address bits addr[2:0] are ignored.
  - MMIO offset 0x00 reads TOHOST last value, 0x08 reads cycle_count, 0x10 reads {32'b0, wr_count}, 0x18 reads {32'b0, err_count}.
  - Unmapped: 0.
  - Reads return the pre-update value in a cycle that also writes the same location.
- Writes, taking effect at posedge:
  - Accepted only in RUN. In CLEAR and HALT they are silently dropped and not counted.
  - A write with addr[2:0]≠0 is dropped and increments err_count.
  - RAM hit: ram[idx] ← wr_data and wr_count increments.
  - Unmapped address: dropped, err_count increments.
  - MMIO 0x00: TOHOST ← wr_data. If wr_data[0]=1, then next cycle done=1 and exit_code=wr_data[63:1]. If wr_data[0]=0, the value is stored and done stays 0.
  - MMIO 0x08, 0x10, 0x18: read-only. Writes are ignored and not counted as errors.
- Counters:
  - cycle_count increments every cycle in RUN and freezes in HALT. The cycle of the TOHOST write is counted.
  - wr_count and err_count saturate at 32'hFFFF_FFFF and do not wrap.
  - cycle_count wraps mod 2^64.
- Debug port: dbg_rd_data ← ram[dbg_addr] at every posedge in all states. A same-cycle core write to the same index returns old data (read-before-write).

Optional Feature:
- Macro DMEM_INIT_CLEAR_EN.
- Defined: after reset the FSM enters CLEAR. It writes 0 to one dword per cycle, index 0 to DEPTH-1. mem_ready rises on the cycle after the last clear write, i.e. DEPTH cycles after rst_n deasserts. Core writes during CLEAR are dropped.
- Undefined: no CLEAR state. The FSM resets directly to RUN, mem_ready is constantly 1 after reset, and RAM contents are uninitialised or retained across reset.

Test Plan:
- Clear: DEPTH=16, CLEAR_EN defined, release rst_n → mem_ready low 16 cycles then high; dbg reads idx 0..15 all 0; cycle_count=0 until ready.
- Store/load: write addr 0x1100 data 64'hDEADBEEF_0000_007B → next cycle rd_data at 0x1100 = that value; dbg_addr=0x220 gives the same one cycle later; MMIO 0x10 reads 1.
- Errors: write 0x1104 → ram[0x220] unchanged, err_count=1. Write 0x9000 (DEPTH 4096) → dropped, err_count=2. Read 0x9000 → 0. Write MMIO+0x08 → err_count stays 2.
- Completion: write TOHOST 64'h2 → done=0. Write TOHOST 64'h7 → done=1 next cycle, exit_code=3, cycle_count frozen; subsequent write to 0x1000 leaves ram[0x200] unchanged and wr_count unchanged.
- Reset mid-clear: DEPTH=16, assert rst_n at clear index 5 → on release, mem_ready rises only after a full 16 cycles; all entries 0.
- Collision: same-cycle write ram[3]=0xAA (old 0x55) with dbg_addr=3 → dbg_rd_data=0x55, then 0xAA the following cycle.
